// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard.
// The operand and slot widths are fixed here so that every slot uses the same packed layout.
package hazard_pkg;

    localparam int AW = 5;
    localparam int TW = 2;

    // A Tuse of 3 marks an operand that the D-stage instruction does not read.
    localparam logic [TW-1:0] TUSE_NONE = 2'd3;
    localparam logic [TW-1:0] TNEW_READY = 2'd0;

    // D-stage operand source.
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2
    } fwd_d_e;

    // E-stage operand source.
    typedef enum logic [1:0] {
        FWD_PIPE   = 2'd0,
        FWD_FROM_M = 2'd1,
        FWD_FROM_W = 2'd2
    } fwd_e_e;

    // M-stage store data source.
    localparam logic FWD_M_PIPE   = 1'b0;
    localparam logic FWD_M_FROM_W = 1'b1;

    // How a slot ages the Tnew field it captures.
    typedef enum logic [1:0] {
        TNEW_HOLD  = 2'd0,
        TNEW_DEC   = 2'd1,
        TNEW_CLEAR = 2'd2
    } tnew_mode_e;

    // One in-flight instruction. dst == 0 means the slot holds no pending write,
    // but rs/rt still describe the instruction for E/M forwarding.
    typedef struct packed {
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } slot_t;

    // Tnew counts down to zero and stays there.
    function automatic logic [TW-1:0] tnew_sat_dec(input logic [TW-1:0] t);
        return (t == TNEW_READY) ? TNEW_READY : t - TW'(1);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline-stage slot of the scoreboard: captures the upstream slot each cycle,
// ageing Tnew on the way in according to the stage it models.
module hazard_slot
    import hazard_pkg::*;
#(
    parameter tnew_mode_e MODE = TNEW_HOLD
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    slot_t d_aged;

    // Apply the stage-specific Tnew ageing to the incoming slot.
    always_comb begin
        // NOTE: every field gets a value before the case so no path leaves d_aged unassigned (no latch).
        d_aged = d;
        case (MODE)
            TNEW_DEC:   d_aged.tnew = tnew_sat_dec(d.tnew);
            TNEW_CLEAR: d_aged.tnew = TNEW_READY;
            default:    d_aged.tnew = d.tnew;
        endcase
    end

    // Slot register; reset empties it immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            // NOTE: non-blocking so all three slots shift from the same pre-edge values.
            q <= d_aged;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard for the 5-stage pipeline: tracks pending writes in E/M/W,
// raises the D-stage stall and selects bypass sources for D, E and M operands.
// W is never a D-stage source because the register file bypasses its own write.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          mdu_busy,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic          fwd_m_rt
);

    slot_t e_q, m_q, w_q;
    slot_t e_d;

    // An operand must wait if a pending producer will not have its result by the time it is used.
    function automatic logic operand_stall(input logic [AW-1:0] addr, input logic [TW-1:0] tuse,
                                           input slot_t e, input slot_t m);
        if (addr == '0 || tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (e.dst == addr && e.tnew > tuse) || (m.dst == addr && m.tnew > tuse);
    endfunction

    // D-stage source: the youngest ready producer wins.
    function automatic fwd_d_e d_source(input logic [AW-1:0] addr, input slot_t e, input slot_t m);
        if (addr == '0) begin
            return FWD_GRF;
        end else if (e.dst == addr && e.tnew == TNEW_READY) begin
            return FWD_E;
        end else if (m.dst == addr && m.tnew == TNEW_READY) begin
            return FWD_M;
        end
        return FWD_GRF;
    endfunction

    // E-stage source: M if its result is ready, otherwise W (whose result always is).
    function automatic fwd_e_e e_source(input logic [AW-1:0] addr, input slot_t m, input slot_t w);
        if (addr == '0) begin
            return FWD_PIPE;
        end else if (m.dst == addr && m.tnew == TNEW_READY) begin
            return FWD_FROM_M;
        end else if (w.dst == addr) begin
            return FWD_FROM_W;
        end
        return FWD_PIPE;
    endfunction

    // Stall and bypass selects, combinational from the slots and the D-stage inputs.
    always_comb begin
        stall = operand_stall(d_rs, d_tuse_rs, e_q, m_q)
              | operand_stall(d_rt, d_tuse_rt, e_q, m_q)
              | (d_is_md & mdu_busy);
        fwd_d_rs = d_source(d_rs, e_q, m_q);
        fwd_d_rt = d_source(d_rt, e_q, m_q);
        fwd_e_rs = e_source(e_q.rs, m_q, w_q);
        fwd_e_rt = e_source(e_q.rt, m_q, w_q);
        fwd_m_rt = (m_q.rt != '0 && w_q.dst == m_q.rt) ? FWD_M_FROM_W : FWD_M_PIPE;
    end

    // E captures the D instruction, or a bubble while D is held.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d = '{dst: d_dst, tnew: d_tnew, rs: d_rs, rt: d_rt};
        end
    end

    hazard_slot #(.MODE(TNEW_HOLD)) u_slot_e (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (e_d),
        .q     (e_q)
    );

    hazard_slot #(.MODE(TNEW_DEC)) u_slot_m (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (e_q),
        .q     (m_q)
    );

    // W results are always available, so its Tnew is forced to zero.
    hazard_slot #(.MODE(TNEW_CLEAR)) u_slot_w (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (m_q),
        .q     (w_q)
    );

    // Slot fields that no compare needs; the slots share one type for uniformity.
    logic unused_fields;
    assign unused_fields = ^{m_q.rs, w_q.tnew, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives one D-stage instruction
// and compares all outputs against hand-derived values.
module tb_hazard_scoreboard;

    import hazard_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic          d_is_md, mdu_busy;
    logic          stall;
    logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic          fwd_m_rt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_dst     (d_dst),
        .d_tnew    (d_tnew),
        .d_is_md   (d_is_md),
        .mdu_busy  (mdu_busy),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .fwd_m_rt  (fwd_m_rt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare every output in one go.
    task automatic expect_out(input string tag, input int s, input int drs, input int drt,
                              input int ers, input int ert, input int mrt);
        check({tag, " stall"},    int'(stall),    s);
        check({tag, " fwd_d_rs"}, int'(fwd_d_rs), drs);
        check({tag, " fwd_d_rt"}, int'(fwd_d_rt), drt);
        check({tag, " fwd_e_rs"}, int'(fwd_e_rs), ers);
        check({tag, " fwd_e_rt"}, int'(fwd_e_rt), ert);
        check({tag, " fwd_m_rt"}, int'(fwd_m_rt), mrt);
    endtask

    task automatic drive(input int rs, input int tu_rs, input int rt, input int tu_rt,
                         input int dst, input int tnew, input int md, input int busy);
        d_rs      = AW'(rs);
        d_tuse_rs = TW'(tu_rs);
        d_rt      = AW'(rt);
        d_tuse_rt = TW'(tu_rt);
        d_dst     = AW'(dst);
        d_tnew    = TW'(tnew);
        d_is_md   = 1'(md);
        mdu_busy  = 1'(busy);
    endtask

    task automatic nop();
        drive(0, 3, 0, 3, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) adv();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        adv();

        // 1. lw $1 (tnew 2) then beq $1 (tuse 0): two stalls with bubbles into E,
        //    after which the result is in W and the register file supplies it.
        drive(0, 3, 0, 3, 1, 2, 0, 0);
        settle(); expect_out("t1 lw", 0, 0, 0, 0, 0, 0);
        adv();
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        settle(); expect_out("t1 stall1", 1, 0, 0, 0, 0, 0);
        adv();
        settle(); expect_out("t1 stall2", 1, 0, 0, 0, 0, 0);
        adv();
        settle(); expect_out("t1 release", 0, 0, 0, 0, 0, 0);
        adv();

        // 2. addu $2 (tnew 1) feeding addu (tuse 1): no stall, E takes from M, then from W.
        drive(0, 3, 0, 3, 2, 1, 0, 0);
        adv();
        drive(2, 1, 0, 3, 3, 1, 0, 0);
        settle(); expect_out("t2 no stall", 0, 0, 0, 0, 0, 0);
        adv();
        drive(2, 1, 0, 3, 4, 1, 0, 0);
        settle(); expect_out("t2 from M", 0, 2, 0, 1, 0, 0);
        adv();
        nop();
        settle(); expect_out("t2 from W", 0, 0, 0, 2, 0, 0);
        flush();

        // 3. Writes to $0 never stall or forward, and $0 reads never match.
        drive(0, 3, 0, 3, 0, 2, 0, 0);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); expect_out("t3 zero dst", 0, 0, 0, 0, 0, 0);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); expect_out("t3 zero src", 0, 0, 0, 0, 0, 0);
        flush();

        // 4. E and M both write $5 ready: D takes E; next cycle E takes M over W.
        drive(0, 3, 0, 3, 5, 0, 0, 0);
        adv();
        drive(0, 3, 0, 3, 5, 0, 0, 0);
        adv();
        drive(5, 0, 5, 0, 0, 0, 0, 0);
        settle(); expect_out("t4 E prio", 0, 1, 1, 0, 0, 0);
        adv();
        drive(5, 0, 0, 3, 0, 0, 0, 0);
        settle(); expect_out("t4 M prio", 0, 2, 0, 1, 1, 0);
        flush();

        // 5. mult/div busy for 4 cycles holds D exactly that long; E stays a bubble.
        drive(0, 3, 0, 3, 0, 0, 0, 1);
        settle(); expect_out("t5 busy no md", 0, 0, 0, 0, 0, 0);
        adv();
        drive(9, 0, 0, 3, 9, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            settle(); expect_out($sformatf("t5 md stall%0d", i), 1, 0, 0, 0, 0, 0);
            adv();
        end
        drive(9, 0, 0, 3, 9, 0, 1, 0);
        settle(); expect_out("t5 md go", 0, 0, 0, 0, 0, 0);
        adv();
        drive(9, 0, 0, 3, 0, 0, 0, 0);
        settle(); expect_out("t5 md in E", 0, 1, 0, 0, 0, 0);
        flush();

        // 6. Reset during a data stall clears it at once; the mult/div term still holds.
        drive(0, 3, 0, 3, 1, 2, 0, 0);
        adv();
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        settle(); expect_out("t6 pre", 1, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1 expect_out("t6 in reset", 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 3, 0, 0, 1, 1);
        #1 expect_out("t6 md held", 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        adv();
        expect_out("t6 reset edge", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 expect_out("t6 released", 0, 0, 0, 0, 0, 0);
        adv();
        // addu $10 (tnew 1), then sw with rt=$10: store data comes from W once addu is there.
        drive(0, 3, 0, 3, 10, 1, 0, 0);
        adv();
        drive(0, 3, 10, 2, 0, 0, 0, 0);
        settle(); expect_out("t6 sw in D", 0, 0, 0, 0, 0, 0);
        adv();
        nop();
        settle(); expect_out("t6 sw in E", 0, 0, 0, 0, 1, 0);
        adv();
        settle(); expect_out("t6 sw in M", 0, 0, 0, 0, 0, 1);
        adv();
        settle(); expect_out("t6 sw in W", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
